// File: rtl/tetris_line_clear_if.sv
// Signal bundle between the piece-lock logic, the line-clear engine and the board/score consumers.
interface tetris_line_clear_if #(
  parameter int BLOCKS_WIDE = 14,
  parameter int BLOCKS_HIGH = 18,
  parameter int ROW_W       = 5
);
  logic                               Pause;
  logic                               Start;
  logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] Game_In;
  logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] Game_Out;
  logic                               Busy;
  logic                               Done;
  logic [ROW_W:0]                     Lines_Cleared;
  logic [15:0]                        Total_Lines;

  modport master (
    output Pause, Start, Game_In,
    input  Game_Out, Busy, Done, Lines_Cleared, Total_Lines
  );

  modport slave (
    input  Pause, Start, Game_In,
    output Game_Out, Busy, Done, Lines_Cleared, Total_Lines
  );
endinterface

// File: rtl/tetris_line_clear.sv
// Line-clear engine: snapshots the board, removes full rows bottom-up and collapses the rows above.
// Optional running total of cleared lines is built only when TETRIS_LINE_CLEAR_TOTAL_EN is defined.
module tetris_line_clear #(
  parameter int BLOCKS_WIDE = 14,
  parameter int BLOCKS_HIGH = 18,
  parameter int ROW_W       = 5
) (
  input logic                Clk,
  input logic                Rst_n,
  tetris_line_clear_if.slave bus
);
  localparam int CELLS = BLOCKS_WIDE * BLOCKS_HIGH;

  typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

  state_t                 state_q, state_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [CELLS-1:0]       board_q, board_d;
  logic [CELLS-1:0]       keep_mask;
  logic [ROW_W:0]         lines_q, lines_d;
  logic [BLOCKS_HIGH-1:0] full_vec;
  logic                   row_full;

  // Rows strictly below the scan row keep their content during a collapse.
  always_comb begin
    full_vec  = '0;
    keep_mask = '0;
    for (int r = 0; r < BLOCKS_HIGH; r++) begin
      full_vec[r] = &board_q[r*BLOCKS_WIDE +: BLOCKS_WIDE];
      if (r > int'(row_q)) keep_mask[r*BLOCKS_WIDE +: BLOCKS_WIDE] = '1;
    end
  end

  assign row_full = full_vec[row_q];

  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    state_d = state_q;
    row_d   = row_q;
    board_d = board_q;
    lines_d = lines_q;
    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          board_d = bus.Game_In;
          row_d   = ROW_W'(BLOCKS_HIGH - 1);
          lines_d = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (row_full) begin
          // Shifting the whole board down one row moves row r-1 into row r and zero-fills row 0.
          board_d = (board_q & keep_mask) | ((board_q << BLOCKS_WIDE) & ~keep_mask);
          lines_d = lines_q + 1'b1;
        end else if (row_q != '0) begin
          row_d = row_q - 1'b1;
        end else begin
          state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      // NOTE: the board is a flop vector rather than a RAM, so it resets along with the rest of the state.
      board_q <= '0;
      lines_q <= '0;
    end else if (!bus.Pause) begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q <= state_d;
      row_q   <= row_d;
      board_q <= board_d;
      lines_q <= lines_d;
    end
  end

`ifdef TETRIS_LINE_CLEAR_TOTAL_EN
  logic [15:0] total_q;
  logic [16:0] total_sum;

  assign total_sum = {1'b0, total_q} + 17'(lines_q);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      total_q <= '0;
    end else if (!bus.Pause && state_q == SCAN && state_d == FINISH) begin
      total_q <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
    end
  end

  assign bus.Total_Lines = total_q;
`else
  assign bus.Total_Lines = 16'h0000;
`endif

  assign bus.Game_Out      = board_q;
  assign bus.Busy          = (state_q != IDLE);
  assign bus.Done          = (state_q == FINISH);
  assign bus.Lines_Cleared = lines_q;

endmodule

// File: tb/tb_tetris_line_clear.sv
// Self-checking bench for tetris_line_clear: directed and random boards against a row-compaction model.
`timescale 1ns/1ps
module tb_tetris_line_clear;
  localparam int W  = 14;
  localparam int H  = 18;
  localparam int RW = 5;
  localparam int N  = W * H;

  typedef logic [N-1:0] board_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   exp_total = 0;

  tetris_line_clear_if #(.BLOCKS_WIDE(W), .BLOCKS_HIGH(H), .ROW_W(RW)) bus ();

  tetris_line_clear #(.BLOCKS_WIDE(W), .BLOCKS_HIGH(H), .ROW_W(RW)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] row_of(board_t b, int r);
    return b[r*W +: W];
  endfunction

  function automatic board_t with_row(board_t b, int r, logic [W-1:0] v);
    b[r*W +: W] = v;
    return b;
  endfunction

  // Reference: keep the non-full rows in order, stacked against the bottom; k counts removed rows.
  function automatic void model_clear(input board_t b, output board_t res, output int k);
    int dst;
    dst = H - 1;
    res = '0;
    k   = 0;
    for (int src = H - 1; src >= 0; src--) begin
      if (row_of(b, src) == '1) k++;
      else begin
        res = with_row(res, dst, row_of(b, src));
        dst--;
      end
    end
  endfunction

  function automatic int required_total();
`ifdef TETRIS_LINE_CLEAR_TOTAL_EN
    return exp_total;
`else
    return 0;
`endif
  endfunction

  function automatic board_t rand_board(int full_pct);
    board_t b;
    b = '0;
    for (int r = 0; r < H; r++) begin
      logic [W-1:0] v;
      if ($urandom_range(99) < full_pct) v = '1;
      else begin
        v = W'($urandom);
        v[$urandom_range(W-1)] = 1'b0;
      end
      b[r*W +: W] = v;
    end
    return b;
  endfunction

  // Runs one pass from IDLE. Cycle 1 is the cycle right after the accepting edge.
  // Returns the cycle Done was first seen (-1 on timeout) and the number of Busy cycles up to it.
  task automatic do_pass(input board_t b, input int pause_at, input int pause_len,
                         input bit mid_start, output int done_cyc, output int busy_cyc);
    int cyc;
    @(posedge clk); #1;
    bus.Game_In = b;
    bus.Start   = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    cyc       = 1;
    done_cyc  = -1;
    busy_cyc  = 0;
    while (cyc < 200) begin
      if (bus.Busy === 1'b1) busy_cyc++;
      if (bus.Done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      bus.Pause = (pause_len > 0 && cyc >= pause_at && cyc < pause_at + pause_len);
      bus.Start = mid_start && (cyc == 5);
      @(posedge clk); #1;
      cyc++;
    end
    bus.Pause = 1'b0;
    bus.Start = 1'b0;
  endtask

  task automatic test_reset();
    bus.Pause   = 1'b0;
    bus.Start   = 1'b0;
    bus.Game_In = '0;
    rst_n       = 1'b0;
    #1;
    n_checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy_done: got busy=%b done=%b, expected 0/0", bus.Busy, bus.Done);
    end
    n_checks++;
    if (bus.Game_Out !== board_t'(0) || bus.Lines_Cleared !== '0 || bus.Total_Lines !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got board=%h lines=%0d total=%0d, expected all zero",
               bus.Game_Out, bus.Lines_Cleared, bus.Total_Lines);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_total = 0;
  endtask

  task automatic run_and_compare(input string name, input board_t b, input int pause_len,
                                 input bit mid_start);
    board_t exp_b;
    int     k, dc, bc, exp_dc;
    model_clear(b, exp_b, k);
    do_pass(b, 4, pause_len, mid_start, dc, bc);
    exp_dc = H + k + 1 + pause_len;
    if (exp_total + k > 16'hFFFF) exp_total = 16'hFFFF;
    else exp_total = exp_total + k;
    n_checks++;
    if (dc !== exp_dc) begin
      n_fail++;
      $display("FAIL %s_done_cycle: got %0d, expected %0d", name, dc, exp_dc);
    end
    n_checks++;
    if (bc !== exp_dc) begin
      n_fail++;
      $display("FAIL %s_busy_cycles: got %0d, expected %0d", name, bc, exp_dc);
    end
    n_checks++;
    if (bus.Lines_Cleared !== (RW+1)'(k)) begin
      n_fail++;
      $display("FAIL %s_lines: got %0d, expected %0d", name, bus.Lines_Cleared, k);
    end
    n_checks++;
    if (bus.Game_Out !== exp_b) begin
      n_fail++;
      $display("FAIL %s_board: got %h, expected %h", name, bus.Game_Out, exp_b);
    end
    n_checks++;
    if (bus.Total_Lines !== 16'(required_total())) begin
      n_fail++;
      $display("FAIL %s_total: got %0d, expected %0d", name, bus.Total_Lines, required_total());
    end
  endtask

  task automatic test_directed();
    board_t b;
    run_and_compare("empty", '0, 0, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (bus.Done !== 1'b0 || bus.Busy !== 1'b0 || bus.Game_Out !== board_t'(0)) begin
      n_fail++;
      $display("FAIL empty_after_done: got done=%b busy=%b, expected 0/0 with board held",
               bus.Done, bus.Busy);
    end
    b = '0;
    b = with_row(b, 17, 14'h3FFF);
    b = with_row(b, 16, 14'h0001);
    run_and_compare("bottom_row", b, 0, 1'b0);
    b = '0;
    b = with_row(b, 17, 14'h3FFF);
    b = with_row(b, 16, 14'h00F0);
    b = with_row(b, 15, 14'h3FFF);
    b = with_row(b, 14, 14'h1000);
    run_and_compare("non_adjacent", b, 0, 1'b0);
    n_checks++;
    if (row_of(bus.Game_Out, 17) !== 14'h00F0 || row_of(bus.Game_Out, 16) !== 14'h1000) begin
      n_fail++;
      $display("FAIL non_adjacent_rows: got r17=%h r16=%h, expected 00f0/1000",
               row_of(bus.Game_Out, 17), row_of(bus.Game_Out, 16));
    end
    run_and_compare("full_board", '1, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) run_and_compare("random", rand_board(30 + 5 * i), 0, 1'b0);
  endtask

  task automatic test_pause_start();
    board_t held;
    run_and_compare("pause_mid_start", rand_board(40), 5, 1'b1);
    held = bus.Game_Out;
    @(posedge clk); #1;
    bus.Pause   = 1'b1;
    bus.Start   = 1'b1;
    bus.Game_In = '1;
    @(posedge clk); #1;
    bus.Pause = 1'b0;
    bus.Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.Busy !== 1'b0) begin
        n_fail++;
        $display("FAIL paused_start_busy: got %b, expected 0", bus.Busy);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (bus.Game_Out !== held) begin
      n_fail++;
      $display("FAIL paused_start_board: got %h, expected %h", bus.Game_Out, held);
    end
  endtask

  task automatic test_reset_mid_pass();
    int done_seen;
    @(posedge clk); #1;
    bus.Game_In = '1;
    bus.Start   = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Game_Out !== board_t'(0) ||
        bus.Lines_Cleared !== '0 || bus.Total_Lines !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid_pass: got busy=%b done=%b lines=%0d total=%0d board=%h, expected zeros",
               bus.Busy, bus.Done, bus.Lines_Cleared, bus.Total_Lines, bus.Game_Out);
    end
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.Done !== 1'b0) done_seen++;
      if (i == 1) rst_n = 1'b1;
    end
    exp_total = 0;
    n_checks++;
    if (done_seen != 0) begin
      n_fail++;
      $display("FAIL reset_mid_pass_done: got %0d Done cycles, expected 0", done_seen);
    end
  endtask

  task automatic test_accumulator();
    int sizes[3] = '{1, 2, 4};
    board_t b;
    for (int p = 0; p < 3; p++) begin
      b = '0;
      for (int r = 0; r < sizes[p]; r++) b = with_row(b, H - 1 - r, '1);
      b = with_row(b, H - 1 - sizes[p], 14'h0155);
      run_and_compare("accumulate", b, 0, 1'b0);
    end
    n_checks++;
`ifdef TETRIS_LINE_CLEAR_TOTAL_EN
    if (bus.Total_Lines !== 16'd7) begin
      n_fail++;
      $display("FAIL accumulate_final: got %0d, expected 7", bus.Total_Lines);
    end
`else
    if (bus.Total_Lines !== 16'd0) begin
      n_fail++;
      $display("FAIL accumulate_final: got %0d, expected 0", bus.Total_Lines);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_pause_start();
    test_reset_mid_pass();
    test_accumulator();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
